card_dealer: RTL and testbench

- Deck controller and arbiter for the blackjack datapath.
- Owns a 52-entry card deck, shuffles it with an LFSR-driven Fisher-Yates pass, and serves card requests from two requesters (player, dealer) under round-robin arbitration.
- Keeps running hand totals with soft-ace handling.
- Sits between blackjack_FSM (requests, round control) and the card renderer (card_valid/rank/suit/slot stream).

---
 rtl/card_dealer.sv | 161 ++++++++++++++++
 tb/tb_card_dealer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - deck owner: init, LFSR Fisher-Yates shuffle, round-robin dealing, soft-ace hand totals
// Define CARD_DEALER_FIXED_DECK_EN to skip the shuffle and deal in init order.
module card_dealer #(
  parameter int          DECK_SIZE = 52,
  parameter int          MAX_CARDS = 6,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle_req,
  input  logic       new_round,
  input  logic       player_req,
  input  logic       dealer_req,
  output logic       shuffle_busy,
  output logic       deck_empty,
  output logic       card_valid,
  output logic       card_dest,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [2:0] card_slot,
  output logic [5:0] player_sum,
  output logic [5:0] dealer_sum,
  output logic       player_bust,
  output logic       dealer_bust
);

  localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);
  localparam logic [5:0] DECK_END = 6'(DECK_SIZE);
  localparam logic [2:0] MAX_SLOT = 3'(MAX_CARDS);

  typedef enum logic [2:0] {IDLE, INIT, SHUFFLE, READY, DEAL} state_t;
  state_t state, state_nx;

  logic [15:0] lfsr;
  logic [5:0]  deck [DECK_SIZE];
  logic [5:0]  idx, ptr, j, card;
  logic [1:0]  suit_cnt;
  logic [3:0]  rank_cnt, value;
  logic        pend_p, pend_d, rr;
  logic [2:0]  slot_p, slot_d, soft_p, soft_d, cur_soft, new_soft;
  logic [5:0]  cur_sum;
  logic [6:0]  new_sum;
  logic        shuffle_go, swap_ok, arm, gsel, hand_full, deal, drop, accept, ready_entry;

  assign shuffle_busy = (state == INIT) || (state == SHUFFLE);
  assign shuffle_go   = shuffle_req && !shuffle_busy;
  assign j            = lfsr[5:0];
  assign swap_ok      = (state == SHUFFLE) && (j <= idx);
  assign arm          = (state == READY) && !new_round && !shuffle_go && (pend_p || pend_d);
  assign gsel         = (pend_p && pend_d) ? ~rr : pend_d;
  assign hand_full    = gsel ? (slot_d == MAX_SLOT) : (slot_p == MAX_SLOT);
  assign deal         = arm && !hand_full && (ptr != DECK_END);
  assign drop         = arm && !deal;
  assign accept       = !shuffle_busy && !deck_empty && !new_round && !shuffle_go;
  assign ready_entry  = shuffle_busy && (state_nx == READY);
  assign player_bust  = player_sum > 6'd21;
  assign dealer_bust  = dealer_sum > 6'd21;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (shuffle_go) state_nx = INIT;
      INIT:    if (idx == LAST_IDX) begin
`ifdef CARD_DEALER_FIXED_DECK_EN
                 state_nx = READY;
`else
                 state_nx = SHUFFLE;
`endif
               end
      SHUFFLE: if (swap_ok && idx == 6'd1) state_nx = READY;
      READY:   if (shuffle_go) state_nx = INIT;
               else if (deal) state_nx = DEAL;
      DEAL:    state_nx = shuffle_go ? INIT : READY;
      default: state_nx = IDLE;
    endcase
  end

  // Value of the pointed card added to the granted hand, with at most one ace softening.
  always_comb begin
    card     = deck[ptr];
    cur_sum  = gsel ? dealer_sum : player_sum;
    cur_soft = gsel ? soft_d : soft_p;
    if (card[3:0] == 4'd1)     value = 4'd11;
    else if (card[3:0] > 4'd10) value = 4'd10;
    else                       value = card[3:0];
    new_sum  = {1'b0, cur_sum} + {3'b000, value};
    new_soft = cur_soft + {2'b00, card[3:0] == 4'd1};
    if (new_sum > 7'd21 && new_soft != 3'd0) begin
      new_sum  = new_sum - 7'd10;
      new_soft = new_soft - 3'd1;
    end
  end

  // Deck contents need no reset: INIT rewrites every entry before use.
  always_ff @(posedge clk) begin
    if (state == INIT) deck[idx] <= {suit_cnt, rank_cnt};
    else if (swap_ok) begin
      deck[idx] <= deck[j];
      deck[j]   <= deck[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
      idx <= '0; suit_cnt <= '0; rank_cnt <= 4'd1; ptr <= '0;
      deck_empty <= 1'b1;
      pend_p <= 1'b0; pend_d <= 1'b0; rr <= 1'b1;
      card_valid <= 1'b0; card_dest <= 1'b0; card_rank <= '0; card_suit <= '0; card_slot <= '0;
      player_sum <= '0; dealer_sum <= '0; soft_p <= '0; soft_d <= '0; slot_p <= '0; slot_d <= '0;
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      card_valid <= 1'b0;
      if (shuffle_go) begin
        idx <= '0; suit_cnt <= '0; rank_cnt <= 4'd1;
      end else if (state == INIT) begin
        if (idx != LAST_IDX) idx <= idx + 6'd1;
        if (rank_cnt == 4'd13) begin
          rank_cnt <= 4'd1;
          suit_cnt <= suit_cnt + 2'd1;
        end else rank_cnt <= rank_cnt + 4'd1;
      end else if (swap_ok) idx <= idx - 6'd1;

      if (ready_entry) begin
        ptr <= '0;
        deck_empty <= 1'b0;
      end else if (state == DEAL && ptr == DECK_END) deck_empty <= 1'b1;

      pend_p <= !(new_round || shuffle_go) &&
                ((pend_p && !((deal || drop) && !gsel)) || (player_req && accept));
      pend_d <= !(new_round || shuffle_go) &&
                ((pend_d && !((deal || drop) && gsel)) || (dealer_req && accept));

      if (new_round || ready_entry) begin
        player_sum <= '0; dealer_sum <= '0; soft_p <= '0; soft_d <= '0; slot_p <= '0; slot_d <= '0;
      end else if (deal) begin
        if (gsel) begin
          dealer_sum <= new_sum[5:0]; soft_d <= new_soft; slot_d <= slot_d + 3'd1;
        end else begin
          player_sum <= new_sum[5:0]; soft_p <= new_soft; slot_p <= slot_p + 3'd1;
        end
      end

      if (deal) begin
        card_valid <= 1'b1;
        card_dest  <= gsel;
        card_suit  <= card[5:4];
        card_rank  <= card[3:0];
        card_slot  <= gsel ? slot_d : slot_p;
        ptr        <= ptr + 6'd1;
        rr         <= gsel;
      end
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - table-driven request rows plus shuffle/hand reference model for card_dealer
module tb_card_dealer;
  logic       clk = 0, rst = 1, shuffle_req = 0, new_round = 0, player_req = 0, dealer_req = 0;
  logic       shuffle_busy, deck_empty, card_valid, card_dest, player_bust, dealer_bust;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic [2:0] card_slot;
  logic [5:0] player_sum, dealer_sum;

  card_dealer dut (
    .clk(clk), .rst(rst), .shuffle_req(shuffle_req), .new_round(new_round),
    .player_req(player_req), .dealer_req(dealer_req), .shuffle_busy(shuffle_busy),
    .deck_empty(deck_empty), .card_valid(card_valid), .card_dest(card_dest),
    .card_rank(card_rank), .card_suit(card_suit), .card_slot(card_slot),
    .player_sum(player_sum), .dealer_sum(dealer_sum),
    .player_bust(player_bust), .dealer_bust(dealer_bust)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic p, d, nr;
    int   n, d0, d1;
  } row_t;

  int          errors = 0, checks = 0;
  logic [15:0] m_lfsr;
  logic [5:0]  m_deck [52];
  int          m_ptr, cards, distinct;
  int          m_sum [2], m_soft [2], m_slot [2];
  int          exp_q [$];
  bit          seen [64];

  function automatic logic [15:0] step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= step(m_lfsr);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_hands();
    for (int s = 0; s < 2; s++) begin
      m_sum[s] = 0; m_soft[s] = 0; m_slot[s] = 0;
    end
  endtask

  task automatic add_card(input int s, input int rank);
    int v;
    v = (rank == 1) ? 11 : (rank > 10) ? 10 : rank;
    m_sum[s] += v;
    if (rank == 1) m_soft[s]++;
    if (m_sum[s] > 21 && m_soft[s] > 0) begin
      m_sum[s] -= 10;
      m_soft[s]--;
    end
    m_slot[s]++;
  endtask

  // Reference deck: ordered init, then Fisher-Yates with rejection sampling on the LFSR stream.
  task automatic model_shuffle(input logic [15:0] l0, output int busy_cycles);
    logic [15:0] l;
    logic [5:0]  t;
    int          i, jj;
    for (int k = 0; k < 52; k++) m_deck[k] = {2'(k / 13), 4'(k % 13 + 1)};
    busy_cycles = 52;
    l = l0;
`ifndef CARD_DEALER_FIXED_DECK_EN
    repeat (53) l = step(l);
    i = 51;
    while (i > 0) begin
      busy_cycles++;
      jj = int'(l[5:0]);
      if (jj <= i) begin
        t = m_deck[i]; m_deck[i] = m_deck[jj]; m_deck[jj] = t;
        i--;
      end
      l = step(l);
    end
`endif
  endtask

  always @(negedge clk) begin
    int d, c;
    if (!rst && card_valid) begin
      cards++;
      c = {card_suit, card_rank};
      if (!seen[c]) begin
        seen[c] = 1'b1;
        distinct++;
      end
      if (exp_q.size() == 0) chk("unexpected_card", 1, 0);
      else begin
        d = exp_q.pop_front();
        chk("dest", int'(card_dest), d);
        chk("slot", int'(card_slot), m_slot[d]);
        chk("card", c, (m_ptr < 52) ? int'(m_deck[m_ptr]) : -1);
        m_ptr++;
        add_card(d, int'(card_rank));
        chk("player_sum", int'(player_sum), m_sum[0]);
        chk("dealer_sum", int'(dealer_sum), m_sum[1]);
        chk("player_bust", int'(player_bust), int'(m_sum[0] > 21));
        chk("dealer_bust", int'(dealer_bust), int'(m_sum[1] > 21));
      end
    end
  end

  task automatic do_row(input logic p, input logic d, input logic nr, input int n, input int d0, input int d1);
    if (nr) clear_hands();
    if (n > 0) exp_q.push_back(d0);
    if (n > 1) exp_q.push_back(d1);
    player_req = p; dealer_req = d; new_round = nr;
    @(negedge clk);
    player_req = 0; dealer_req = 0; new_round = 0;
    @(negedge clk);
    chk("valid_n2", int'(card_valid), int'(n > 0));
    @(negedge clk);
    chk("valid_n3", int'(card_valid), 0);
    @(negedge clk);
    chk("valid_n4", int'(card_valid), int'(n > 1));
    @(negedge clk);
  endtask

  task automatic do_shuffle();
    int nb, n;
    @(negedge clk);
    model_shuffle(m_lfsr, nb);
    shuffle_req = 1;
    @(negedge clk);
    shuffle_req = 0;
    chk("busy_start", int'(shuffle_busy), 1);
    n = 0;
    while (shuffle_busy && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk("shuffle_cycles", n, nb);
`ifndef CARD_DEALER_FIXED_DECK_EN
    chk("shuffle_min_103", int'(n >= 103), 1);
`endif
    chk("empty_after_shuffle", int'(deck_empty), 0);
    m_ptr = 0;
    clear_hands();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(shuffle_busy), 0);
    chk({tag, "_empty"}, int'(deck_empty), 1);
    chk({tag, "_valid"}, int'(card_valid), 0);
    chk({tag, "_rank"}, int'(card_rank), 0);
    chk({tag, "_psum"}, int'(player_sum), 0);
    chk({tag, "_dsum"}, int'(dealer_sum), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    row_t rows [13];
    rows[0]  = '{1'b1, 1'b1, 1'b0, 2, 0, 1};
    rows[1]  = '{1'b1, 1'b1, 1'b0, 2, 0, 1};
    rows[2]  = '{1'b0, 1'b0, 1'b1, 0, 0, 0};
    for (int k = 3; k <= 8; k++) rows[k] = '{1'b1, 1'b0, 1'b0, 1, 0, 0};
    rows[9]  = '{1'b1, 1'b0, 1'b0, 0, 0, 0};
    rows[10] = '{1'b1, 1'b0, 1'b1, 0, 0, 0};
    rows[11] = '{1'b0, 1'b1, 1'b0, 1, 1, 0};
    rows[12] = '{1'b1, 1'b0, 1'b0, 1, 0, 0};

    clear_hands();
    m_ptr = 0; cards = 0; distinct = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 0;
    @(negedge clk);
    chk_reset_outputs("idle");
    do_row(1'b1, 1'b0, 1'b0, 0, 0, 0);

    do_shuffle();
    for (int r = 0; r < 13; r++)
      do_row(rows[r].p, rows[r].d, rows[r].nr, rows[r].n, rows[r].d0, rows[r].d1);
    chk("table_queue_drained", exp_q.size(), 0);

    do_shuffle();
    cards = 0; distinct = 0;
    for (int c = 0; c < 64; c++) seen[c] = 1'b0;
    for (int k = 0; k < 52; k++) begin
      if (k > 0 && k % 4 == 0) do_row(1'b0, 1'b0, 1'b1, 0, 0, 0);
      do_row(k % 2 == 0, k % 2 == 1, 1'b0, 1, k % 2, 0);
    end
    chk("cards_dealt", cards, 52);
    chk("distinct_cards", distinct, 52);
    chk("deck_empty_after_52", int'(deck_empty), 1);
    do_row(1'b1, 1'b0, 1'b0, 0, 0, 0);
    chk("no_53rd_card", cards, 52);

    @(negedge clk);
    shuffle_req = 1;
    @(negedge clk);
    shuffle_req = 0;
    repeat (58) @(negedge clk);
    chk("busy_mid_shuffle", int'(shuffle_busy), 1);
    #1 rst = 1;
    #1 chk_reset_outputs("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    do_shuffle();
    do_row(1'b0, 1'b1, 1'b0, 1, 1, 0);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
